mult_arbiter: RTL and testbench

//   Shares one multi-cycle 32x32->64 multiplier core between NREQ requesters.

---
 rtl/mult_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mult_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// Round-robin front end that shares one multi-cycle 32x32->64 multiplier core
// between NREQ requesters, with a single id-tagged response channel.
module mult_arbiter #(
  parameter int NREQ = 2,
  parameter int W    = 32,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_signed,
  output logic [NREQ-1:0]   req_ready,
  output logic              resp_valid,
  output logic [IDW-1:0]    resp_id,
  output logic [2*W-1:0]    resp_z,
  input  logic              resp_ready,
  output logic              mul_start,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  output logic              mul_signed,
  input  logic              mul_done,
  input  logic [2*W-1:0]    mul_z,
  output logic [15:0]       op_count,
  output logic [1:0]        dbg_state
);

  // Handshakes: request i transfers on a rising edge where req_valid[i] and
  // req_ready[i] are both high; the response transfers on a rising edge where
  // resp_valid and resp_ready are both high. Valid may not depend on ready.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic             mul_start_q, mul_start_d;
  logic [W-1:0]     mul_a_q, mul_a_d;
  logic [W-1:0]     mul_b_q, mul_b_d;
  logic             mul_signed_q, mul_signed_d;
  logic             resp_valid_q, resp_valid_d;
  logic [IDW-1:0]   resp_id_q, resp_id_d;
  logic [2*W-1:0]   resp_z_q, resp_z_d;
  logic [15:0]      op_count_q, op_count_d;

  int               cand_i;
  logic [IDW-1:0]   cand;
  logic             grant_found;
  logic [IDW-1:0]   grant_id;
  logic [W-1:0]     sel_a;
  logic [W-1:0]     sel_b;
  logic             sel_signed;
  logic             accept;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    cand_i      = 0;
    cand        = '0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_i = int'(rr_ptr_q) + k;
      if (cand_i >= NREQ) cand_i = cand_i - NREQ;
      cand = IDW'(cand_i);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_comb begin
    sel_a      = '0;
    sel_b      = '0;
    sel_signed = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == grant_id) begin
        sel_a      = req_a[i*W +: W];
        sel_b      = req_b[i*W +: W];
        sel_signed = req_signed[i];
      end
    end
  end

  assign accept = (state_q == S_IDLE) && grant_found;

  // Gated by reset so no grant is ever visible while reset is asserted.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = accept && (IDW'(i) == grant_id) && reset;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    mul_start_d  = 1'b0;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    mul_signed_d = mul_signed_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_z_d     = resp_z_q;
    op_count_d   = op_count_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mul_a_d      = sel_a;
          mul_b_d      = sel_b;
          mul_signed_d = sel_signed;
          resp_id_d    = grant_id;
          rr_ptr_d     = grant_id;
          // A zero operand makes the product zero; skip the core entirely.
          if (sel_a == '0 || sel_b == '0) begin
            resp_z_d     = '0;
            resp_valid_d = 1'b1;
            state_d      = S_RESP;
          end else begin
            mul_start_d = 1'b1;
            state_d     = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mul_done) begin
          resp_z_d     = mul_z;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          op_count_d   = op_count_q + 16'd1;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= IDW'(NREQ - 1);
      mul_start_q  <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_signed_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_z_q     <= '0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      mul_start_q  <= mul_start_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      mul_signed_q <= mul_signed_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_z_q     <= resp_z_d;
      op_count_q   <= op_count_d;
    end
  end

  assign mul_start  = mul_start_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign mul_signed = mul_signed_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_z     = resp_z_q;
  assign op_count   = op_count_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: behavioural core model, id/product scoreboard and
// latency/arbitration checks against a plain-arithmetic reference.
module tb_mult_arbiter;
  localparam int NREQ = 2;
  localparam int W    = 32;
  localparam int IDW  = 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0]   req_signed = '0;
  logic [NREQ-1:0]   req_ready;
  logic              resp_valid;
  logic [IDW-1:0]    resp_id;
  logic [2*W-1:0]    resp_z;
  logic              resp_ready = 1'b0;
  logic              mul_start;
  logic [W-1:0]      mul_a;
  logic [W-1:0]      mul_b;
  logic              mul_signed;
  logic              mul_done;
  logic [2*W-1:0]    mul_z;
  logic [15:0]       op_count;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [2*W-1:0] exp_q[$];
  int             id_q[$];
  logic [15:0]    exp_ops = '0;
  int             model_rr = NREQ - 1;

  mult_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_signed(req_signed),
    .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_z(resp_z), .resp_ready(resp_ready),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_signed(mul_signed),
    .mul_done(mul_done), .mul_z(mul_z),
    .op_count(op_count), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sg);
    longint sa, sb;
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [W-1:0] rnd_op();
    if ($urandom_range(0, 5) == 0) return '0;
    return $urandom();
  endfunction

  // behavioural multiplier core: done pulse k cycles after the start cycle
  int             core_k = 4;
  logic           core_done = 1'b0;
  logic           stray_done = 1'b0;
  logic [2*W-1:0] core_z = '0;
  bit             core_busy = 1'b0;
  logic [W-1:0]   core_a, core_b;
  logic           core_s;
  int             core_kk;
  assign mul_done = core_done | stray_done;
  assign mul_z    = core_z;

  initial begin
    forever begin
      @(negedge clk);
      if (mul_start === 1'b1) begin
        core_busy = 1'b1;
        core_a = mul_a; core_b = mul_b; core_s = mul_signed; core_kk = core_k;
        repeat (core_kk) @(negedge clk);
        core_z = ref_mul(core_a, core_b, core_s);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        core_busy = 1'b0;
      end
    end
  end

  // driver: one full transaction on requester id, optionally stalling the response
  task automatic run_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sg, input int k, input int hold, input bit bg);
    int t_acc, t_resp, exp_lat, exp_id, oid;
    bit got, zero;
    logic [2*W-1:0] exp_z;
    oid = (id == 0) ? 1 : 0;
    zero = (a == '0) || (b == '0);
    core_k = k;
    @(negedge clk);
    req_valid[id] = 1'b1;
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_signed[id] = sg;
    got = 1'b0;
    t_acc = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (req_ready[id] === 1'b1) begin
        got = 1'b1;
        t_acc = cyc;
      end
      @(negedge clk);
    end
    req_valid[id] = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL accept_timeout: req%0d got no ready, required ready within 20 cycles", id);
      return;
    end
    exp_q.push_back(ref_mul(a, b, sg));
    id_q.push_back(id);
    model_rr = id;

    checks++;
    if (mul_start !== !zero) begin
      errors++;
      $display("FAIL start_pulse: mul_start=%0b, required %0b", mul_start, !zero);
    end
    checks++;
    if (mul_a !== a || mul_b !== b || mul_signed !== sg) begin
      errors++;
      $display("FAIL latched_ops: a=%h b=%h s=%0b, required a=%h b=%h s=%0b",
               mul_a, mul_b, mul_signed, a, b, sg);
    end

    t_resp = -1;
    for (int i = 0; i < 200; i++) begin
      if (resp_valid === 1'b1) begin
        t_resp = cyc;
        break;
      end
      @(negedge clk);
    end
    exp_lat = zero ? t_acc + 1 : t_acc + 2 + k;
    checks++;
    if (t_resp != exp_lat) begin
      errors++;
      $display("FAIL resp_latency: resp_valid at cycle %0d, required %0d", t_resp, exp_lat);
      if (t_resp < 0) return;
    end
    exp_z = exp_q.pop_front();
    exp_id = id_q.pop_front();

    if (bg) req_valid[oid] = 1'b1;
    for (int h = 0; h < hold; h++) begin
      #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== IDW'(exp_id) || resp_z !== exp_z) begin
        errors++;
        $display("FAIL hold_stable: valid=%0b id=%0d z=%h, required valid=1 id=%0d z=%h",
                 resp_valid, resp_id, resp_z, exp_id, exp_z);
      end
      checks++;
      if (req_ready !== 2'b00) begin
        errors++;
        $display("FAIL grant_in_resp: req_ready=%b, required 00", req_ready);
      end
      @(negedge clk);
    end
    checks++;
    if (resp_id !== IDW'(exp_id) || resp_z !== exp_z) begin
      errors++;
      $display("FAIL resp_data: id=%0d z=%h, required id=%0d z=%h", resp_id, resp_z, exp_id, exp_z);
    end
    resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL grant_at_handshake: req_ready=%b, required 00", req_ready);
    end
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid[oid] = 1'b0;
    exp_ops = exp_ops + 16'd1;
    checks++;
    if (resp_valid !== 1'b0 || op_count !== exp_ops) begin
      errors++;
      $display("FAIL after_handshake: valid=%0b op_count=%0d, required valid=0 op_count=%0d",
               resp_valid, op_count, exp_ops);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (req_ready !== '0 || resp_valid !== 1'b0 || resp_id !== '0 || resp_z !== '0 ||
        mul_start !== 1'b0 || mul_a !== '0 || mul_b !== '0 || mul_signed !== 1'b0 ||
        op_count !== '0) begin
      errors++;
      $display("FAIL %s: rdy=%b rv=%0b id=%0d z=%h st=%0b a=%h b=%h s=%0b cnt=%0d, required all 0",
               name, req_ready, resp_valid, resp_id, resp_z, mul_start, mul_a, mul_b,
               mul_signed, op_count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b1;
    exp_ops = '0;
    model_rr = NREQ - 1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op(0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 32, 0, 1'b0);
    run_op(1, 32'hFFFF_FFF8, 32'hFFFF_FFFB, 1'b1, 5, 0, 1'b0);
    run_op(1, 32'h0000_0008, 32'h0000_0005, 1'b0, 3, 1, 1'b0);
    run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4, 0, 1'b0);
  endtask

  task automatic test_zero_hold();
    run_op(0, 32'h0000_1234, 32'h0000_0000, 1'b0, 3, 5, 1'b1);
    run_op(1, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 3, 2, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      run_op($urandom_range(0, 1), rnd_op(), rnd_op(), 1'($urandom_range(0, 1)),
             $urandom_range(1, 8), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
  endtask

  // back-to-back: both requesters always valid, consumer always ready
  task automatic test_back_to_back();
    logic [W-1:0] op_a [NREQ];
    logic [W-1:0] op_b [NREQ];
    logic         op_s [NREQ];
    int resps, upd, g_exp;
    logic [2*W-1:0] ez;
    int eid;
    resps = 0;
    core_k = $urandom_range(1, 5);
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = rnd_op(); op_b[i] = rnd_op(); op_s[i] = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = op_a[i]; req_b[i*W +: W] = op_b[i]; req_signed[i] = op_s[i];
    end
    req_valid = 2'b11;
    resp_ready = 1'b1;
    for (int c = 0; c < 400 && resps < 12; c++) begin
      #1;
      upd = -1;
      if (resp_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_unexpected_resp: id=%0d z=%h, required no response", resp_id, resp_z);
        end else begin
          ez = exp_q.pop_front();
          eid = id_q.pop_front();
          if (resp_id !== IDW'(eid) || resp_z !== ez) begin
            errors++;
            $display("FAIL b2b_resp: id=%0d z=%h, required id=%0d z=%h", resp_id, resp_z, eid, ez);
          end
        end
        exp_ops = exp_ops + 16'd1;
        resps++;
      end
      if (req_ready !== 2'b00) begin
        g_exp = (model_rr + 1) % NREQ;
        checks++;
        if (req_ready !== 2'(1 << g_exp)) begin
          errors++;
          $display("FAIL b2b_grant: req_ready=%b, required %b", req_ready, 2'(1 << g_exp));
        end
        exp_q.push_back(ref_mul(op_a[g_exp], op_b[g_exp], op_s[g_exp]));
        id_q.push_back(g_exp);
        model_rr = g_exp;
        upd = g_exp;
      end
      @(negedge clk);
      if (upd >= 0) begin
        op_a[upd] = rnd_op(); op_b[upd] = rnd_op(); op_s[upd] = 1'($urandom_range(0, 1));
        req_a[upd*W +: W] = op_a[upd]; req_b[upd*W +: W] = op_b[upd];
        req_signed[upd] = op_s[upd];
      end
    end
    req_valid = '0;
    resp_ready = 1'b0;
    checks++;
    if (resps != 12 || op_count !== exp_ops) begin
      errors++;
      $display("FAIL b2b_count: responses=%0d op_count=%0d, required 12 and %0d",
               resps, op_count, exp_ops);
    end
    exp_q.delete();
    id_q.delete();
  endtask

  task automatic test_reset_mid_op();
    bit got;
    int seen_valid;
    core_k = 20;
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_a[W +: W] = 32'h0000_0077;
    req_b[W +: W] = 32'h0000_0013;
    req_signed[1] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (req_ready[1] === 1'b1) got = 1'b1;
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL rst_accept: req1 got no ready, required ready within 20 cycles");
    end
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    check_all_zero("reset_mid_op");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_ops = '0;
    model_rr = NREQ - 1;
    @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 40 && core_busy; i++) begin
      if (resp_valid !== 1'b0) seen_valid++;
      @(negedge clk);
    end
    repeat (3) begin
      if (resp_valid !== 1'b0) seen_valid++;
      @(negedge clk);
    end
    checks++;
    if (seen_valid != 0 || core_busy) begin
      errors++;
      $display("FAIL stray_done: resp_valid cycles=%0d core_busy=%0b, required 0 and 0",
               seen_valid, core_busy);
    end
    check_all_zero("after_stray_done");
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL first_grant_after_reset: req_ready=%b, required 01", req_ready);
    end
    req_valid = '0;
    run_op(1, 32'h0000_0003, 32'h0000_0009, 1'b0, 2, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_hold();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running at time limit");
    $fatal(1, "timeout");
  end

endmodule
